srt_radix2_iter: RTL and testbench

- Sequential radix-2 SRT iteration core of the single-precision SRT divider.
- Unpacks two IEEE-754 operands and forms the sign and the pre-normalised exponent.
- Runs 24 SRT iterations with on-the-fly quotient conversion, then applies a final negative-remainder correction.
- Sits directly upstream of the post-processing/normaliser stage and drives its result, shift_nums, right_shift, resultsign and current_exponent inputs.

---
 rtl/srt_radix2_iter.sv | 102 ++++++++++
 tb/tb_srt_radix2_iter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/srt_radix2_iter.sv
// srt_radix2_iter: radix-2 SRT divider iteration core; SRT_SPECIAL_CASE_EN adds IEEE special-case decode
module srt_radix2_iter #(
    parameter int ITERS = 24,
    parameter int RW    = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        out_valid,
    output logic [23:0] result,
    output logic [4:0]  shift_nums,
    output logic        right_shift,
    output logic        resultsign,
    output logic [7:0]  current_exponent
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    localparam logic signed [RW:0] HALF = (RW+1)'(1) << (RW-3);
    state_t state, state_nx;
    logic sign, spc, spc_nx;
    logic [9:0] exp, e0, eadj, exp_nx;
    logic [23:0] q_reg, qm_reg, d, ma, mb, spc_res, spc_res_nx;
    logic [4:0] count;
    logic signed [RW-1:0] r;
    logic signed [RW:0] tr, dd, r_nx;
    logic ge, pos, neg, accept;
    assign ma     = {1'b1, dividend[22:0]};
    assign mb     = {1'b1, divisor[22:0]};
    assign ge     = ma >= mb;
    assign e0     = 10'(dividend[30:23]) - 10'(divisor[30:23]) + 10'd127;
    assign eadj   = ge ? e0 : e0 - 10'd1;
    assign accept = state == IDLE && start;
    assign tr     = {r, 1'b0};
    assign dd     = (RW+1)'({d, 1'b0});
    assign pos    = tr >= HALF;
    assign neg    = tr < -HALF;
    assign r_nx   = pos ? tr - dd : neg ? tr + dd : tr;
`ifdef SRT_SPECIAL_CASE_EN
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan_c, inf_c, zero_c, ovf, unf;
    assign a_zero = dividend[30:0] == 31'd0;
    assign b_zero = divisor[30:0] == 31'd0;
    assign a_inf  = dividend[30:23] == 8'hFF && dividend[22:0] == 23'd0;
    assign b_inf  = divisor[30:23] == 8'hFF && divisor[22:0] == 23'd0;
    assign a_nan  = dividend[30:23] == 8'hFF && dividend[22:0] != 23'd0;
    assign b_nan  = divisor[30:23] == 8'hFF && divisor[22:0] != 23'd0;
    assign nan_c  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    assign inf_c  = b_zero || a_inf;
    assign zero_c = a_zero || b_inf;
    assign ovf    = $signed(eadj) > 10'sd254;
    assign unf    = $signed(eadj) < 10'sd1;
    assign spc_nx = nan_c || inf_c || zero_c || ovf || unf;
    assign spc_res_nx = nan_c ? 24'hC00000 : (inf_c ? 24'h800000 : (zero_c ? 24'h0 : (ovf ? 24'h800000 : 24'h0)));
    assign exp_nx = (nan_c || inf_c) ? 10'd255 : (zero_c ? 10'd0 : (ovf ? 10'd255 : (unf ? 10'd0 : eadj)));
`else
    assign spc_nx     = 1'b0;
    assign spc_res_nx = 24'h0;
    assign exp_nx     = eadj;
`endif
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = start ? ITER : IDLE;
        else if (state == ITER) state_nx = count == 5'(ITERS-1) ? FIX : ITER;
        else state_nx = IDLE;
    end
    always_comb busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {sign, spc, exp, q_reg, qm_reg, d, spc_res, count, r} <= '0;
            {out_valid, result, shift_nums, right_shift, resultsign, current_exponent} <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                sign    <= dividend[31] ^ divisor[31];
                d       <= mb;
                r       <= ge ? RW'(ma) : RW'({ma, 1'b0});
                exp     <= exp_nx;
                spc     <= spc_nx;
                spc_res <= spc_res_nx;
                q_reg   <= '0;
                qm_reg  <= '0;
                count   <= '0;
            end else if (state == ITER) begin
                r      <= r_nx[RW-1:0];
                q_reg  <= pos ? {q_reg[22:0], 1'b1} : neg ? {qm_reg[22:0], 1'b1} : {q_reg[22:0], 1'b0};
                qm_reg <= pos ? {q_reg[22:0], 1'b0} : neg ? {qm_reg[22:0], 1'b0} : {qm_reg[22:0], 1'b1};
                count  <= count + 5'd1;
            end else if (state == FIX) begin
                result           <= spc ? spc_res : (r < 0 ? qm_reg : q_reg);
                current_exponent <= exp[7:0];
                resultsign       <= sign;
                shift_nums       <= '0;
                right_shift      <= 1'b0;
                out_valid        <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_srt_radix2_iter.sv
// tb_srt_radix2_iter: directed scoreboard bench for srt_radix2_iter
module tb_srt_radix2_iter;
    logic clk = 0, rst_n = 0, start = 0;
    logic [31:0] dividend = 0, divisor = 0;
    logic busy, out_valid, right_shift, resultsign;
    logic [23:0] result;
    logic [4:0] shift_nums;
    logic [7:0] current_exponent;
    int total = 0, bad = 0;
    typedef struct {logic [23:0] res; logic [7:0] e; logic s;} exp_t;
    exp_t sb[$];

    srt_radix2_iter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .out_valid(out_valid), .result(result), .shift_nums(shift_nums),
        .right_shift(right_shift), .resultsign(resultsign), .current_exponent(current_exponent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [23:0] res,
                          input logic [7:0] e, input logic s, input bit push);
        exp_t x;
        x.res = res; x.e = e; x.s = s;
        if (push) sb.push_back(x);
        start = 1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 0; dividend = $urandom; divisor = $urandom;
    endtask

    task automatic wait_result(input string tag, input int pre);
        int n = pre;
        exp_t x;
        for (int i = 0; i < 60 && !out_valid; i++) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 25);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_result"}, result, x.res);
            chk({tag, "_exp"}, current_exponent, x.e);
            chk({tag, "_sign"}, resultsign, x.s);
            chk({tag, "_shift"}, {right_shift, shift_nums}, 0);
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_outs", {result, current_exponent, resultsign, right_shift, shift_nums}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        launch(32'h3F800000, 32'h3F800000, 24'h800000, 8'd127, 1'b0, 1);
        chk("one_busy", busy, 1);
        wait_result("one", 0);
        launch(32'h40400000, 32'h40000000, 24'hC00000, 8'd127, 1'b0, 1);
        chk("pulse_one_cycle", out_valid, 0);
        wait_result("three_half", 0);
        launch(32'h3F800000, 32'h40400000, 24'hAAAAAA, 8'd125, 1'b0, 1);
        wait_result("third", 0);

        launch(32'hC0C00000, 32'h40000000, 24'hC00000, 8'd128, 1'b1, 1);
        repeat (9) begin @(posedge clk); #1; end
        start = 1; dividend = 32'h3F800000; divisor = 32'h40400000;
        @(posedge clk); #1;
        start = 0;
        chk("ignored_busy", busy, 1);
        wait_result("neg6_2", 10);
        chk("held_after_valid", {result, current_exponent}, {24'hC00000, 8'd128});
        quiet("no_queued_start", 30);
        chk("hold_result", result, 24'hC00000);

        launch(32'h3F800000, 32'h3F800000, 24'h0, 8'd0, 1'b0, 0);
        repeat (12) begin @(posedge clk); #1; end
        chk("mid_hold", result, 24'hC00000);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort_outs", {busy, out_valid, result, current_exponent, resultsign, right_shift, shift_nums}, 0);
        quiet("abort_no_valid", 30);

        launch(32'h40400000, 32'h40000000, 24'hC00000, 8'd127, 1'b0, 1);
        wait_result("b2b_a", 0);
        launch(32'h3F800000, 32'h40400000, 24'hAAAAAA, 8'd125, 1'b0, 1);
        chk("b2b_accept_busy", busy, 1);
        wait_result("b2b_b", 0);
`ifdef SRT_SPECIAL_CASE_EN
        launch(32'h3F800000, 32'h00000000, 24'h800000, 8'd255, 1'b0, 1);
        wait_result("div_zero", 0);
        launch(32'h7FC00000, 32'h40000000, 24'hC00000, 8'd255, 1'b0, 1);
        wait_result("nan", 0);
        launch(32'h00000000, 32'h40000000, 24'h000000, 8'd0, 1'b0, 1);
        wait_result("zero_num", 0);
`endif
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
